// File: rtl/buzzer_driver.sv
// buzzer_driver
//   Decodes the control FSM's buzzer command and plays a fixed beep pattern on
//   the piezo pin. A one-cycle done pulse at the end of the pattern lets the
//   control FSM leave its CORRECT/WRONG state.
//
// Ports
//   clk         system clock, rising edge
//   resetN      asynchronous active-low reset
//   buzzerMode  00 off, 01 reserved (off), 10 correct, 11 wrong
//   buzzerOut   registered square wave to the piezo, low when silent
//   buzzerDone  one-cycle pulse when the pattern completes
//   busy        high whenever the FSM is not idle
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a 10/11 command
// TONE    | playing a tone; pitch and length chosen by the latched mode
// GAP     | silence between the two CORRECT beeps
// DONE    | single-cycle completion pulse
// RELEASE | waiting for the command to drop so the pattern cannot retrigger

module buzzer_driver #(
  parameter int HALF_HI      = 25_000,
  parameter int HALF_LO      = 100_000,
  parameter int BEEP_CYCLES  = 10_000_000,
  parameter int GAP_CYCLES   = 5_000_000,
  parameter int WRONG_CYCLES = 30_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [1:0] buzzerMode,
  output logic       buzzerOut,
  output logic       buzzerDone,
  output logic       busy
);

  localparam int DUR_MAX = (BEEP_CYCLES > GAP_CYCLES)
                         ? ((BEEP_CYCLES > WRONG_CYCLES) ? BEEP_CYCLES : WRONG_CYCLES)
                         : ((GAP_CYCLES  > WRONG_CYCLES) ? GAP_CYCLES  : WRONG_CYCLES);
  localparam int HALF_MAX = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;

  // Keep at least one bit so degenerate parameter sets still elaborate.
  localparam int DUR_W  = (DUR_MAX  > 1) ? $clog2(DUR_MAX)  : 1;
  localparam int HALF_W = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  localparam logic [DUR_W-1:0]  BEEP_LAST  = DUR_W'(BEEP_CYCLES - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST   = DUR_W'(GAP_CYCLES - 1);
  localparam logic [DUR_W-1:0]  WRONG_LAST = DUR_W'(WRONG_CYCLES - 1);
  localparam logic [HALF_W-1:0] HI_LAST    = HALF_W'(HALF_HI - 1);
  localparam logic [HALF_W-1:0] LO_LAST    = HALF_W'(HALF_LO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TONE,
    S_GAP,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t              state, state_next;
  logic                modeLatched, modeLatched_next;
  logic                beepIdx, beepIdx_next;
  logic [DUR_W-1:0]    durCnt, durCnt_next;
  logic [HALF_W-1:0]   halfCnt, halfCnt_next;
  logic                out_reg, out_next;
  logic [DUR_W-1:0]    len_last;
  logic [HALF_W-1:0]   half_last;
  logic                cmd_active;

  // Only 10 and 11 are live commands, so bit 1 alone says "keep playing".
  assign cmd_active = buzzerMode[1];

  assign len_last  = modeLatched ? WRONG_LAST : BEEP_LAST;
  assign half_last = modeLatched ? LO_LAST    : HI_LAST;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      modeLatched <= 1'b0;
      beepIdx     <= 1'b0;
      durCnt      <= '0;
      halfCnt     <= '0;
      out_reg     <= 1'b0;
    end else begin
      state       <= state_next;
      modeLatched <= modeLatched_next;
      beepIdx     <= beepIdx_next;
      durCnt      <= durCnt_next;
      halfCnt     <= halfCnt_next;
      out_reg     <= out_next;
    end
  end

  // Counters and the output default to zero so that every entry into TONE or
  // GAP starts from a clean, low state regardless of the path taken.
  always_comb begin
    state_next       = state;
    modeLatched_next = modeLatched;
    beepIdx_next     = beepIdx;
    durCnt_next      = '0;
    halfCnt_next     = '0;
    out_next         = 1'b0;

    case (state)
      S_IDLE: begin
        if (buzzerMode == 2'b10) begin
          modeLatched_next = 1'b0;
          beepIdx_next     = 1'b0;
          state_next       = S_TONE;
        end else if (buzzerMode == 2'b11) begin
          modeLatched_next = 1'b1;
          beepIdx_next     = 1'b0;
          state_next       = S_TONE;
        end
      end

      S_TONE: begin
        if (!cmd_active) begin
          state_next = S_IDLE;
        end else if (durCnt == len_last) begin
          if (!modeLatched && !beepIdx) state_next = S_GAP;
          else                          state_next = S_DONE;
        end else begin
          durCnt_next = durCnt + 1'b1;
          if (halfCnt == half_last) begin
            out_next = ~out_reg;
          end else begin
            halfCnt_next = halfCnt + 1'b1;
            out_next     = out_reg;
          end
        end
      end

      S_GAP: begin
        if (!cmd_active) begin
          state_next = S_IDLE;
        end else if (durCnt == GAP_LAST) begin
          beepIdx_next = 1'b1;
          state_next   = S_TONE;
        end else begin
          durCnt_next = durCnt + 1'b1;
        end
      end

      S_DONE: begin
        state_next = S_RELEASE;
      end

      S_RELEASE: begin
        if (!cmd_active) state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign buzzerOut  = out_reg;
  assign buzzerDone = (state == S_DONE);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_buzzer_driver.sv
module tb_buzzer_driver;

  localparam int HH = 2;
  localparam int HL = 4;
  localparam int BC = 10;
  localparam int GC = 5;
  localparam int WC = 30;

  logic       clk;
  logic       resetN;
  logic [1:0] mode;
  logic       buzzerOut;
  logic       buzzerDone;
  logic       busy;

  int tests = 0;
  int fails = 0;

  buzzer_driver #(
    .HALF_HI(HH), .HALF_LO(HL), .BEEP_CYCLES(BC),
    .GAP_CYCLES(GC), .WRONG_CYCLES(WC)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .buzzerMode(mode),
    .buzzerOut(buzzerOut),
    .buzzerDone(buzzerDone),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pattern model: position within the pattern is a single phase number
  // counted from the first tone cycle; outputs are derived from it.
  bit m_active;
  bit m_release;
  bit m_wrong;
  int m_phase;

  function automatic int pat_len();
    return m_wrong ? WC : (2 * BC + GC);
  endfunction

  function automatic bit exp_out();
    if (!m_active) return 1'b0;
    if (m_wrong) return (m_phase < WC) && (((m_phase / HL) % 2) == 1);
    if (m_phase < BC) return ((m_phase / HH) % 2) == 1;
    if (m_phase >= BC + GC && m_phase < 2 * BC + GC)
      return (((m_phase - BC - GC) / HH) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic bit exp_done();
    return m_active && (m_phase == pat_len());
  endfunction

  function automatic bit exp_busy();
    return m_active || m_release;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_active  = 1'b0;
      m_release = 1'b0;
      m_wrong   = 1'b0;
      m_phase   = 0;
    end else if (m_active) begin
      if (m_phase == pat_len()) begin
        m_active  = 1'b0;
        m_release = 1'b1;
      end else if (!mode[1]) begin
        m_active = 1'b0;
      end else begin
        m_phase++;
      end
    end else if (m_release) begin
      if (!mode[1]) m_release = 1'b0;
    end else if (mode == 2'b10 || mode == 2'b11) begin
      m_active = 1'b1;
      m_wrong  = mode[0];
      m_phase  = 0;
    end
  end

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetN) begin
      check("model_out",  int'(buzzerOut),  int'(exp_out()));
      check("model_done", int'(buzzerDone), int'(exp_done()));
      check("model_busy", int'(busy),       int'(exp_busy()));
    end
  end

  // Cycle 0 is the cycle in which the first command is presented. After the
  // done pulse, the command drops to 00 'hold' cycles later.
  task automatic run_cmd(input logic [1:0] first, input int switch_at,
                         input logic [1:0] switch_val, input int hold,
                         input int max_cyc,
                         output int done_at, output int done_n,
                         output int rises, output int idle_at, output int busy_n);
    bit prev_out;
    done_at = -1; done_n = 0; rises = 0; idle_at = -1; busy_n = 0;
    prev_out = 1'b0;
    for (int i = 0; i <= max_cyc; i++) begin
      @(negedge clk);
      if (buzzerDone) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (buzzerOut && !prev_out) rises++;
      prev_out = buzzerOut;
      if (busy) busy_n++;
      if (done_at >= 0 && idle_at < 0 && !busy) idle_at = i;
      if (i == 0) mode = first;
      else if (i == switch_at) mode = switch_val;
      if (done_at >= 0 && i == done_at + hold) mode = 2'b00;
    end
    mode = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, n, r, idl, b;
    resetN = 1'b0;
    mode   = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_out",  int'(buzzerOut),  0);
    check("rst_done", int'(buzzerDone), 0);
    check("rst_busy", int'(busy),       0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Correct pattern
    run_cmd(2'b10, -1, 2'b00, 1, 40, d, n, r, idl, b);
    check("correct_done_at", d, 26);
    check("correct_done_n",  n, 1);
    check("correct_rises",   r, 4);
    check("correct_idle_at", idl, 28);
    check("correct_busy_n",  b, 27);

    // Wrong pattern
    run_cmd(2'b11, -1, 2'b00, 1, 45, d, n, r, idl, b);
    check("wrong_done_at", d, 31);
    check("wrong_done_n",  n, 1);
    check("wrong_rises",   r, 4);
    check("wrong_idle_at", idl, 33);

    // Held command: stays in RELEASE, no retrigger
    run_cmd(2'b10, -1, 2'b00, 20, 60, d, n, r, idl, b);
    check("held_done_at", d, 26);
    check("held_done_n",  n, 1);
    check("held_idle_at", idl, 47);
    run_cmd(2'b10, -1, 2'b00, 1, 40, d, n, r, idl, b);
    check("held_again_done_at", d, 26);

    // Abort at cycle 8
    run_cmd(2'b11, 8, 2'b00, 1, 40, d, n, r, idl, b);
    check("abort_done_n", n, 0);
    check("abort_busy_n", b, 8);
    check("abort_rises",  r, 1);

    // Reserved mode
    run_cmd(2'b01, -1, 2'b00, 1, 50, d, n, r, idl, b);
    check("reserved_busy_n", b, 0);
    check("reserved_rises",  r, 0);
    check("reserved_done_n", n, 0);

    // 10 switched to 11 at cycle 3
    run_cmd(2'b10, 3, 2'b11, 1, 40, d, n, r, idl, b);
    check("switch_done_at", d, 26);
    check("switch_rises",   r, 4);
    check("switch_done_n",  n, 1);

    // Asynchronous reset mid-tone
    @(negedge clk);
    mode = 2'b11;
    repeat (6) @(negedge clk);
    check("midtone_out_high", int'(buzzerOut), 1);
    check("midtone_busy",     int'(busy),      1);
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_out",  int'(buzzerOut),  0);
    check("async_rst_done", int'(buzzerDone), 0);
    check("async_rst_busy", int'(busy),       0);
    mode = 2'b00;
    @(negedge clk);
    resetN = 1'b1;
    run_cmd(2'b00, -1, 2'b00, 1, 10, d, n, r, idl, b);
    check("post_rst_busy_n", b, 0);
    check("post_rst_rises",  r, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/buzzer_driver.md
# buzzer_driver

Consumer end of the control FSM's buzzer interface. Decodes the 2-bit `buzzerMode` command, drives a square-wave piezo output with a fixed beep pattern per mode, and returns a one-cycle `buzzerDone` pulse when the pattern finishes, which releases the control FSM from its CORRECT or WRONG state. Sits between the control FSM and the board's buzzer pin.

## Interface
- `HALF_HI`, default 25_000: clock cycles per half-period of the high-pitch tone used for CORRECT.
- `HALF_LO`, default 100_000: clock cycles per half-period of the low-pitch tone used for WRONG.
- `BEEP_CYCLES`, default 10_000_000: length of one CORRECT beep.
- `GAP_CYCLES`, default 5_000_000: silence between the two CORRECT beeps.
- `WRONG_CYCLES`, default 30_000_000: length of the single WRONG tone.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `buzzerMode`  in  2  command from the control FSM:
  - 00 = off
  - 10 = correct
  - 11 = wrong
  - 01 = reserved, treated as off
- `buzzerOut`  out  1  square wave to the piezo. Low when silent.
- `buzzerDone`  out  1  one-cycle pulse at pattern completion.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, TONE, GAP, DONE, RELEASE.
- Registers:
  - `modeLatched` (1 bit: 0 = correct, 1 = wrong)
  - `beepIdx` (1 bit)
  - `durCnt`, width `$clog2(max(BEEP_CYCLES, GAP_CYCLES, WRONG_CYCLES))`
  - `halfCnt`, width `$clog2(max(HALF_HI, HALF_LO))`
- Reset (`resetN` low, asynchronous): state IDLE, `buzzerOut`=0, `buzzerDone`=0, `busy`=0, all counters 0. Reset may be asserted at any point, including mid-tone.
- IDLE:
  - If `buzzerMode`==10: latch correct, set `beepIdx`=0, go to TONE.
  - If `buzzerMode`==11: latch wrong, go to TONE.
  - Otherwise stay in IDLE.
- TONE:
  - `halfCnt` counts 0..HALF-1, where HALF is HALF_HI for correct and HALF_LO for wrong.
  - At HALF-1, `buzzerOut` toggles and `halfCnt` clears.
  - `durCnt` counts 0..LEN-1, where LEN is BEEP_CYCLES for correct and WRONG_CYCLES for wrong.
  - At LEN-1:
    - correct, `beepIdx`=0: go to GAP.
    - correct, `beepIdx`=1: go to DONE.
    - wrong: go to DONE.
- GAP:
  - `buzzerOut` held 0.
  - `durCnt` counts 0..GAP_CYCLES-1.
  - At the end: set `beepIdx`=1, go to TONE.
- DONE:
  - `buzzerDone`=1 for exactly this one cycle.
  - `buzzerOut`=0.
  - Go to RELEASE.
- RELEASE:
  - Stay until `buzzerMode` ∉ {10, 11}, then go to IDLE.
  - Prevents retriggering while the control FSM is still leaving its state.
- Counter and output behaviour:
  - `durCnt`, `halfCnt` and `buzzerOut` clear to 0 on every entry to TONE or GAP.
  - Every tone therefore starts low.
- Abort: in TONE or GAP, if `buzzerMode` reads 00 or 01, go directly to IDLE. `buzzerOut` is 0 next cycle and no `buzzerDone` pulse is produced.
- Mode change mid-pattern between 10 and 11 is ignored; `modeLatched` governs the whole pattern.
- `buzzerDone` and `busy` are decoded from the state register only. `buzzerOut` is a register. No combinational path from `buzzerMode` to any output.

## Timing
- Command sampled at edge k in IDLE: TONE and `busy`=1 from cycle k+1.
- First `buzzerOut` rising edge occurs HALF cycles after TONE entry.
- Correct:
  - TONE: BEEP_CYCLES
  - GAP: GAP_CYCLES
  - TONE: BEEP_CYCLES
  - DONE: 1 cycle
  - `buzzerDone` is high in cycle k+1+2·BEEP_CYCLES+GAP_CYCLES.
- Wrong: `buzzerDone` is high in cycle k+1+WRONG_CYCLES.
- The control FSM samples `buzzerDone` at the end of DONE. `buzzerMode` reads 00 one cycle later, in RELEASE, so IDLE is reached 2 cycles after DONE.
- `busy` is low in IDLE only.
- The earliest a new command can be accepted is the first IDLE cycle after RELEASE.

## Test plan
Test parameters: HALF_HI=2, HALF_LO=4, BEEP_CYCLES=10, GAP_CYCLES=5, WRONG_CYCLES=30.

- Correct pattern: `buzzerMode`=10 at cycle 0, cleared to 00 the cycle after `buzzerDone` → `buzzerOut` toggles every 2 cycles for 10 cycles, low for 5, toggles for 10 more; exactly one `buzzerDone` pulse at cycle 26; IDLE by cycle 28.
- Wrong pattern: `buzzerMode`=11 at cycle 0 → `buzzerOut` toggles every 4 cycles for 30 cycles; `buzzerDone` is a single pulse at cycle 31.
- Held mode: keep `buzzerMode`=10 for 20 cycles after `buzzerDone` → block stays in RELEASE, `busy`=1, no second pattern; after the release to 00, a fresh 10 starts a new pattern.
- Abort: `buzzerMode`=11, then 00 at cycle 8 → `buzzerOut`=0 and `busy`=0 within 1 cycle; no `buzzerDone` pulse.
- Reset mid-tone: assert `resetN`=0 asynchronously during TONE → `buzzerOut`, `buzzerDone` and `busy` go 0 immediately, without waiting for a clock edge; after release with `buzzerMode`=00, the block stays in IDLE.
- Reserved and switched modes:
  - `buzzerMode`=01 for 50 cycles → no output activity.
  - 10 switched to 11 at cycle 3 → the correct pattern completes unchanged.
